// File: rtl/ece751_h264_enc_axil_regs.sv
// AXI4-Lite slave register block for the H.264 encoder core: four config words, STATUS, start/done handshake.
// Optional: define ECE751_H264_ENC_SLVERR_EN to answer unmapped reads and writes with SLVERR.
`timescale 1ns/1ps

module ece751_h264_enc_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [127:0]                    cfg_regs,
  output logic                            enc_start,
  input  logic                            enc_busy,
  input  logic                            enc_done
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef ECE751_H264_ENC_SLVERR_EN
  localparam logic [1:0] RESP_UNMAPPED = RESP_SLVERR;
`else
  localparam logic [1:0] RESP_UNMAPPED = RESP_OKAY;
`endif

  localparam logic [2:0] IDX_STATUS = 3'd4;

  logic [31:0] cfg_reg [4];
  logic        done_flag;
  logic [15:0] done_cnt;

  logic [2:0]  wr_idx;
  logic [2:0]  rd_idx;
  logic        wr_fire;
  logic        rd_fire;
  logic        wr_mapped;
  logic        rd_mapped;
  logic        done_w1c;
  logic [31:0] status_word;
  logic [31:0] rd_mux;

  // Byte-lane offset within the word carries no meaning in this map.
  logic        unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign wr_idx    = s00_axi_awaddr[4:2];
  assign rd_idx    = s00_axi_araddr[4:2];
  assign wr_mapped = (wr_idx <= IDX_STATUS);
  assign rd_mapped = (rd_idx <= IDX_STATUS);

  // AW and W are taken together, and only while no write response is pending.
  assign wr_fire         = s00_axi_awvalid & s00_axi_wvalid & ~s00_axi_bvalid;
  assign s00_axi_awready = wr_fire;
  assign s00_axi_wready  = wr_fire;

  assign s00_axi_arready = ~s00_axi_rvalid;
  assign rd_fire         = s00_axi_arvalid & ~s00_axi_rvalid;

  assign done_w1c = wr_fire & (wr_idx == IDX_STATUS) & s00_axi_wstrb[0] & s00_axi_wdata[1];

  // NOTE: the config words feed the core directly, so this small array is
  // reset like any other flop rather than left to power-up contents.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      for (int i = 0; i < 4; i++) cfg_reg[i] <= '0;
    end else if (wr_fire && !wr_idx[2]) begin
      for (int b = 0; b < 4; b++) begin
        if (s00_axi_wstrb[b]) cfg_reg[wr_idx[1:0]][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
      end
    end
  end

  assign cfg_regs = {cfg_reg[3], cfg_reg[2], cfg_reg[1], cfg_reg[0]};

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      s00_axi_bvalid <= 1'b0;
      s00_axi_bresp  <= RESP_OKAY;
    end else if (wr_fire) begin
      s00_axi_bvalid <= 1'b1;
      s00_axi_bresp  <= wr_mapped ? RESP_OKAY : RESP_UNMAPPED;
    end else if (s00_axi_bready) begin
      s00_axi_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      enc_start <= 1'b0;
    end else begin
      enc_start <= wr_fire & (wr_idx == 3'd0) & s00_axi_wstrb[0] & s00_axi_wdata[0];
    end
  end

  // A frame completing on the same edge as a software clear must not be lost.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      done_flag <= 1'b0;
      done_cnt  <= '0;
    end else begin
      if (enc_done) begin
        done_flag <= 1'b1;
        done_cnt  <= done_cnt + 16'd1;
      end else if (done_w1c) begin
        done_flag <= 1'b0;
      end
    end
  end

  assign status_word = {done_cnt, 14'd0, done_flag, enc_busy};

  // NOTE: every path assigns rd_mux after its default, so no latch is inferred.
  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      3'd0, 3'd1, 3'd2, 3'd3: rd_mux = cfg_reg[rd_idx[1:0]];
      IDX_STATUS:             rd_mux = status_word;
      default:                rd_mux = '0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      s00_axi_rvalid <= 1'b0;
      s00_axi_rdata  <= '0;
      s00_axi_rresp  <= RESP_OKAY;
    end else if (rd_fire) begin
      s00_axi_rvalid <= 1'b1;
      s00_axi_rdata  <= rd_mux;
      s00_axi_rresp  <= rd_mapped ? RESP_OKAY : RESP_UNMAPPED;
    end else if (s00_axi_rready) begin
      s00_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ece751_h264_enc_axil_regs.sv
// Scoreboard bench for ece751_h264_enc_axil_regs: directed scenarios plus randomized AXI-Lite traffic
// against a word-level register model. Honours ECE751_H264_ENC_SLVERR_EN for expected responses.
`timescale 1ns/1ps

module tb_ece751_h264_enc_axil_regs;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   awaddr;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [4:0]   araddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] cfg_regs;
  logic         enc_start;
  logic         enc_busy;
  logic         enc_done;

  always #5 clk = ~clk;

  ece751_h264_enc_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .cfg_regs(cfg_regs), .enc_start(enc_start), .enc_busy(enc_busy), .enc_done(enc_done)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] m_reg [4];
  logic        m_done;
  logic [15:0] m_cnt;
  logic        wr_pend;
  logic [4:0]  wr_a;
  logic [31:0] wr_d;
  logic [3:0]  wr_s;
  logic        start_now;
  int          start_seen = 0;
  logic [31:0] last_rdata;
  bit          rand_core = 0;
  bit          hold_b = 0;
  rexp_t       rq[$];
  logic [1:0]  bq[$];
  rexp_t       r_e;
  logic [1:0]  b_e;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_resp(input logic [4:0] a);
`ifdef ECE751_H264_ENC_SLVERR_EN
    return (a >= 5'h14) ? 2'b10 : 2'b00;
`else
    return 2'b00;
`endif
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a < 5'h10) return m_reg[a[3:2]];
    if (a < 5'h14) return {m_cnt, 14'd0, m_done, enc_busy};
    return 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = '0;
    m_done = 0; m_cnt = 0; wr_pend = 0; start_now = 0;
    bq.delete(); rq.delete();
  endtask

  // Reference model: applies the write accepted on each edge, then the core's done pulse.
  initial forever begin
    @(posedge clk);
    if (!rst) begin
      start_now = 0;
      if (wr_pend) begin
        wr_pend = 0;
        if (wr_a < 5'h10) begin
          for (int b = 0; b < 4; b++) if (wr_s[b]) m_reg[wr_a[3:2]][8*b +: 8] = wr_d[8*b +: 8];
        end
        if (wr_a >= 5'h10 && wr_a < 5'h14 && wr_s[0] && wr_d[1]) m_done = 0;
        if (wr_a < 5'h04 && wr_s[0] && wr_d[0]) start_now = 1;
      end
      if (enc_done) begin
        m_done = 1;
        m_cnt  = 16'((int'(m_cnt) + 1) % 65536);
      end
    end
  end

  // Monitor: pops the scoreboard whenever a response handshake is about to complete.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (start_now || enc_start) check("enc_start", enc_start, start_now);
      if (enc_start) start_seen++;
      if (bvalid && bready) begin
        if (bq.size() == 0) check("b_unexpected", bvalid, 0);
        else begin
          b_e = bq.pop_front();
          check("bresp", bresp, b_e);
          check("cfg_regs", cfg_regs, {m_reg[3], m_reg[2], m_reg[1], m_reg[0]});
        end
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) check("r_unexpected", rvalid, 0);
        else begin
          r_e = rq.pop_front();
          last_rdata = rdata;
          check("rdata", rdata, r_e.data);
          check("rresp", rresp, r_e.resp);
        end
      end
    end
  end

  initial begin
    bready = 0; rready = 0;
    forever begin
      @(posedge clk); #1;
      bready = hold_b ? 1'b0 : ($urandom_range(0, 3) != 0);
      rready = ($urandom_range(0, 3) != 0);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_core) begin
      enc_busy = 1'($urandom_range(0, 1));
      enc_done = ($urandom_range(0, 5) == 0);
    end
  end

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
    forever begin
      @(negedge clk);
      if (awready && wready) begin
        wr_pend = 1; wr_a = a; wr_d = d; wr_s = s;
        bq.push_back(exp_resp(a));
        break;
      end
      if (++n > 500) begin check("aw_timeout", awready, 1); break; end
    end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
  endtask

  task automatic axi_read(input logic [4:0] a);
    int n = 0;
    @(posedge clk); #1;
    araddr = a; arvalid = 1;
    forever begin
      @(negedge clk);
      if (arready) begin
        rq.push_back('{data: exp_read(a), resp: exp_resp(a)});
        break;
      end
      if (++n > 500) begin check("ar_timeout", arready, 1); break; end
    end
    @(posedge clk); #1;
    arvalid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (bq.size() == 0 && rq.size() == 0 && !bvalid && !rvalid) break;
      if (++n > 2000) begin check("idle_timeout", bvalid | rvalid, 0); break; end
    end
  endtask

  initial begin
    int s0;
    logic [31:0] d;
    logic [4:0]  a1, a2;
    rst = 1;
    awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    araddr = 0; arvalid = 0; enc_busy = 0; enc_done = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);
    check("rst_enc_start", enc_start, 0);
    check("rst_cfg_regs", cfg_regs, 0);
    check("rst_arready", arready, 1);
    check("rst_awready", awready, 0);
    @(negedge clk); rst = 0;

    // Basic write/read-back of all four config words.
    s0 = start_seen;
    for (int i = 0; i < 4; i++) axi_write(5'(4 * i), 32'(i + 1), 4'hF);
    for (int i = 0; i < 4; i++) axi_read(5'(4 * i));
    wait_idle();
    check("cfg_regs_1234", cfg_regs, 128'h00000004_00000003_00000002_00000001);
    check("start_pulses", start_seen - s0, 1);

    // Byte strobes.
    axi_write(5'h04, 32'h0, 4'hF);
    axi_write(5'h04, 32'hAABBCCDD, 4'b0101);
    axi_read(5'h06);
    wait_idle();
    check("strobe_reg1", cfg_regs[63:32], 32'h00BB00DD);

    // Three frames done while busy, then W1C.
    enc_busy = 1;
    repeat (3) begin
      @(posedge clk); #1 enc_done = 1;
      @(posedge clk); #1 enc_done = 0;
    end
    axi_read(5'h10);
    wait_idle();
    check("status_3done", last_rdata, 32'h00030003);
    axi_write(5'h10, 32'h2, 4'h1);
    axi_read(5'h10);
    wait_idle();
    check("status_w1c", last_rdata, 32'h00030001);

    // Counter wrap: hold the done input until the count reaches 0xFFFF.
    @(posedge clk); #1 enc_done = 1;
    repeat (16'hFFFF - m_cnt) @(posedge clk);
    #1 enc_done = 0;
    axi_read(5'h10);
    wait_idle();
    check("cnt_ffff", last_rdata[31:16], 16'hFFFF);
    @(posedge clk); #1 enc_done = 1;
    @(posedge clk); #1 enc_done = 0;
    axi_read(5'h10);
    wait_idle();
    check("cnt_wrap", last_rdata[31:16], 16'h0000);
    check("cnt_wrap_done", last_rdata[1], 1);

    // Done pulse on the same edge as the W1C clear: set wins.
    @(posedge clk); #1;
    awaddr = 5'h10; wdata = 32'h2; wstrb = 4'h1; awvalid = 1; wvalid = 1; enc_done = 1;
    @(negedge clk);
    check("w1c_same_edge_accept", awready, 1);
    if (awready) begin
      wr_pend = 1; wr_a = 5'h10; wr_d = 32'h2; wr_s = 4'h1;
      bq.push_back(exp_resp(5'h10));
    end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; enc_done = 0;
    axi_read(5'h10);
    wait_idle();
    check("set_wins", last_rdata[1], 1);

    // Unmapped read, then a write response held off by bready.
    axi_read(5'h18);
    wait_idle();
    check("unmapped_rdata", last_rdata, 0);
    hold_b = 1;
    axi_write(5'h1C, 32'hDEADBEEF, 4'hF);
    awaddr = 5'h08; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_bvalid", bvalid, 1);
      check("hold_awready", awready, 0);
    end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; hold_b = 0;
    axi_write(5'h08, 32'h12345678, 4'hF);
    axi_read(5'h08);
    wait_idle();

    // Randomized traffic with a randomly behaving core.
    rand_core = 1;
    for (int i = 0; i < 250; i++) begin
      a1 = 5'($urandom);
      a2 = ($urandom_range(0, 1) == 0) ? a1 : 5'($urandom);
      d  = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: axi_write(a1, d, 4'($urandom));
        4, 5, 6:    axi_read(a1);
        default: fork
          axi_write(a1, d, 4'($urandom));
          axi_read(a2);
        join
      endcase
    end
    rand_core = 0;
    @(posedge clk); #1 enc_done = 0;
    wait_idle();

    // Reset in the middle of a write whose response is still pending.
    hold_b = 1;
    axi_write(5'h04, 32'hCAFEF00D, 4'hF);
    #2 rst = 1;
    #1;
    check("midrst_bvalid", bvalid, 0);
    check("midrst_cfg_regs", cfg_regs, 0);
    check("midrst_rvalid", rvalid, 0);
    model_reset();
    hold_b = 0;
    @(negedge clk); rst = 0;
    axi_write(5'h0C, 32'h0BADC0DE, 4'hF);
    axi_read(5'h0C);
    wait_idle();
    check("post_rst_reg3", last_rdata, 32'h0BADC0DE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
